// File: rtl/pic_init_sequencer.sv
// 8259A command-word sequencer: synchronises the CPU write strobe and commits ICW1-ICW4 / OCW1-OCW3.
// Define PIC_SEQ_ERR_EN to add the sticky seq_err output that flags ignored writes.
module pic_init_sequencer #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IMR_INIT    = 8'h00
) (
    input  logic       clk,
    input  logic       reset_bar,
    input  logic       write_strobe,
    input  logic       A0,
    input  logic [7:0] data_in,
    output logic       init_done,
    output logic [4:0] vector_base,
    output logic       single_mode,
    output logic       ltim,
    output logic [7:0] cascade_cfg,
    output logic       upm,
    output logic       aeoi,
    output logic       master_slave,
    output logic       buf_mode,
    output logic       sfnm,
    output logic [7:0] imr,
    output logic       ocw2_valid,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_level,
    output logic       rotate_aeoi,
    output logic       special_mask,
    output logic       read_isr_sel,
`ifdef PIC_SEQ_ERR_EN
    output logic       seq_err,
`endif
    output logic       poll_cmd
);

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   s_prev;
    logic                   armed;
    logic                   ic4;
    logic [8:0]             hold;
    logic                   s;
    logic                   commit;
    logic                   hold_a0;
    logic [7:0]             hold_d;

    assign s       = sync[SYNC_STAGES-1];
    assign commit  = s_prev & ~s & armed;
    assign hold_a0 = hold[8];
    assign hold_d  = hold[7:0];

    // fill tracks when the last sync stage holds a genuine sample, so a strobe
    // already high at reset release can never arm the commit logic.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            sync   <= '0;
            fill   <= '0;
            s_prev <= 1'b0;
            armed  <= 1'b0;
            hold   <= '0;
        end else begin
            sync[0] <= write_strobe;
            fill[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
                fill[i] <= fill[i-1];
            end
            s_prev <= s;
            if (fill[SYNC_STAGES-1] && !s)
                armed <= 1'b1;
            if (s)
                hold <= {A0, data_in};
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state        <= WAIT_ICW1;
            ic4          <= 1'b0;
            init_done    <= 1'b0;
            vector_base  <= '0;
            single_mode  <= 1'b0;
            ltim         <= 1'b0;
            cascade_cfg  <= '0;
            upm          <= 1'b0;
            aeoi         <= 1'b0;
            master_slave <= 1'b0;
            buf_mode     <= 1'b0;
            sfnm         <= 1'b0;
            imr          <= IMR_INIT;
            ocw2_valid   <= 1'b0;
            ocw2_cmd     <= '0;
            ocw2_level   <= '0;
            rotate_aeoi  <= 1'b0;
            special_mask <= 1'b0;
            read_isr_sel <= 1'b0;
            poll_cmd     <= 1'b0;
`ifdef PIC_SEQ_ERR_EN
            seq_err      <= 1'b0;
`endif
        end else begin
            ocw2_valid <= 1'b0;
            poll_cmd   <= 1'b0;
            if (commit) begin
                if (!hold_a0 && hold_d[4]) begin
                    // ICW1 restarts initialisation from any state
                    single_mode  <= hold_d[1];
                    ltim         <= hold_d[3];
                    ic4          <= hold_d[0];
                    vector_base  <= '0;
                    cascade_cfg  <= '0;
                    {sfnm, buf_mode, master_slave, aeoi, upm} <= '0;
                    rotate_aeoi  <= 1'b0;
                    special_mask <= 1'b0;
                    read_isr_sel <= 1'b0;
                    imr          <= IMR_INIT;
                    init_done    <= 1'b0;
                    state        <= WAIT_ICW2;
`ifdef PIC_SEQ_ERR_EN
                    seq_err      <= 1'b0;
`endif
                end else if (hold_a0) begin
                    case (state)
                        WAIT_ICW2: begin
                            vector_base <= hold_d[7:3];
                            if (!single_mode) begin
                                state <= WAIT_ICW3;
                            end else if (ic4) begin
                                state <= WAIT_ICW4;
                            end else begin
                                state     <= READY;
                                init_done <= 1'b1;
                            end
                        end
                        WAIT_ICW3: begin
                            cascade_cfg <= hold_d;
                            if (ic4) begin
                                state <= WAIT_ICW4;
                            end else begin
                                state     <= READY;
                                init_done <= 1'b1;
                            end
                        end
                        WAIT_ICW4: begin
                            {sfnm, buf_mode, master_slave, aeoi, upm} <= hold_d[4:0];
                            state     <= READY;
                            init_done <= 1'b1;
                        end
                        READY: begin
                            imr <= hold_d;
                        end
                        default: begin
`ifdef PIC_SEQ_ERR_EN
                            seq_err <= 1'b1;
`endif
                        end
                    endcase
                end else if (state != READY) begin
`ifdef PIC_SEQ_ERR_EN
                    seq_err <= 1'b1;
`endif
                end else if (!hold_d[3]) begin
                    ocw2_valid <= 1'b1;
                    ocw2_cmd   <= hold_d[7:5];
                    ocw2_level <= hold_d[2:0];
                    if (hold_d[7:5] == 3'b100)
                        rotate_aeoi <= 1'b1;
                    else if (hold_d[7:5] == 3'b000)
                        rotate_aeoi <= 1'b0;
                end else begin
                    if (hold_d[6])
                        special_mask <= hold_d[5];
                    if (hold_d[1])
                        read_isr_sel <= hold_d[0];
                    if (hold_d[2])
                        poll_cmd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Self-checking bench for pic_init_sequencer: directed init/OCW sequences plus random writes,
// compared every cycle against a behavioural command-word model.
module tb_pic_init_sequencer;

    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] IMR_INIT    = 8'hC3;

    logic       clk = 1'b0;
    logic       reset_bar = 1'b0;
    logic       write_strobe = 1'b0;
    logic       A0 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       init_done, single_mode, ltim, upm, aeoi, master_slave, buf_mode, sfnm;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg, imr;
    logic       ocw2_valid, rotate_aeoi, special_mask, read_isr_sel, poll_cmd;
    logic [2:0] ocw2_cmd, ocw2_level;
    logic       dut_err;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 0;

    // Model: phase is the next ICW number expected (1..4), or 5 once initialised.
    int         m_phase;
    logic       m_ic4, m_sngl, m_ltim, m_valid, m_poll, m_rot, m_smm, m_risr, m_err;
    logic [4:0] m_vb, m_icw4;
    logic [7:0] m_cas, m_imr;
    logic [2:0] m_cmd, m_level;

    logic       snap_valid, snap_valid_after, snap_poll, snap_poll_after;
    logic [2:0] snap_cmd, snap_level;

    pic_init_sequencer #(.SYNC_STAGES(SYNC_STAGES), .IMR_INIT(IMR_INIT)) dut (
        .clk(clk), .reset_bar(reset_bar), .write_strobe(write_strobe), .A0(A0),
        .data_in(data_in), .init_done(init_done), .vector_base(vector_base),
        .single_mode(single_mode), .ltim(ltim), .cascade_cfg(cascade_cfg), .upm(upm),
        .aeoi(aeoi), .master_slave(master_slave), .buf_mode(buf_mode), .sfnm(sfnm),
        .imr(imr), .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
        .rotate_aeoi(rotate_aeoi), .special_mask(special_mask), .read_isr_sel(read_isr_sel),
`ifdef PIC_SEQ_ERR_EN
        .seq_err(dut_err),
`endif
        .poll_cmd(poll_cmd)
    );

`ifndef PIC_SEQ_ERR_EN
    assign dut_err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_phase = 1; m_ic4 = 0; m_sngl = 0; m_ltim = 0; m_vb = '0; m_cas = '0; m_icw4 = '0;
        m_imr = IMR_INIT; m_valid = 0; m_cmd = '0; m_level = '0; m_rot = 0; m_smm = 0;
        m_risr = 0; m_poll = 0; m_err = 0;
    endtask

    task automatic modelCommit(input logic a0, input logic [7:0] d);
        if (!a0 && d[4]) begin
            m_sngl = d[1]; m_ltim = d[3]; m_ic4 = d[0];
            m_vb = '0; m_cas = '0; m_icw4 = '0; m_rot = 0; m_smm = 0; m_risr = 0;
            m_imr = IMR_INIT; m_phase = 2; m_err = 0;
        end else if (a0) begin
            if (m_phase == 1) m_err = 1;
            else if (m_phase == 2) begin
                m_vb = d[7:3];
                m_phase = !m_sngl ? 3 : (m_ic4 ? 4 : 5);
            end else if (m_phase == 3) begin
                m_cas = d;
                m_phase = m_ic4 ? 4 : 5;
            end else if (m_phase == 4) begin
                m_icw4 = d[4:0];
                m_phase = 5;
            end else m_imr = d;
        end else if (m_phase != 5) m_err = 1;
        else if (!d[3]) begin
            m_valid = 1; m_cmd = d[7:5]; m_level = d[2:0];
            if (d[7:5] == 3'b100) m_rot = 1;
            if (d[7:5] == 3'b000) m_rot = 0;
        end else begin
            if (d[6]) m_smm = d[5];
            if (d[1]) m_risr = d[0];
            if (d[2]) m_poll = 1;
        end
    endtask

    // Every-cycle compare; command/level only matter while the pulse is expected.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("outputs",
                {32'(0), init_done, vector_base, single_mode, ltim, cascade_cfg,
                 sfnm, buf_mode, master_slave, aeoi, upm, imr, ocw2_valid,
                 (m_valid ? ocw2_cmd : 3'b0), (m_valid ? ocw2_level : 3'b0),
                 rotate_aeoi, special_mask, read_isr_sel, poll_cmd, dut_err},
                {32'(0), (m_phase == 5), m_vb, m_sngl, m_ltim, m_cas, m_icw4, m_imr, m_valid,
                 (m_valid ? m_cmd : 3'b0), (m_valid ? m_level : 3'b0),
                 m_rot, m_smm, m_risr, m_poll,
`ifdef PIC_SEQ_ERR_EN
                 m_err
`else
                 1'b0
`endif
                });
        end
    end

    task automatic applyStimulus(input logic a0, input logic [7:0] d, input int width);
        @(negedge clk);
        A0 = a0; data_in = d; write_strobe = 1'b1;
        repeat (width) @(negedge clk);
        write_strobe = 1'b0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1;
        modelCommit(a0, d);
        snap_valid = ocw2_valid; snap_cmd = ocw2_cmd; snap_level = ocw2_level; snap_poll = poll_cmd;
        @(posedge clk);
        #1;
        m_valid = 0; m_poll = 0;
        snap_valid_after = ocw2_valid; snap_poll_after = poll_cmd;
        A0 = 1'($urandom); data_in = 8'($urandom);
    endtask

    initial begin
        int r;
        logic a0r;
        logic [7:0] dr;

        modelReset();
        repeat (3) @(negedge clk);
        reset_bar = 1'b1;
        check_en = 1;
        #1;
        checkOutput("reset imr", 64'(imr), 64'(IMR_INIT));
        checkOutput("reset init_done", 64'(init_done), 64'(0));

        // A0=1 before any ICW1 must be ignored
        applyStimulus(1'b1, 8'h55, SYNC_STAGES + 2);
        checkOutput("ignored icw1-state vb", 64'(vector_base), 64'(0));

        // Strobe high across reset release must not commit
        @(negedge clk);
        check_en = 0;
        A0 = 1'b0; data_in = 8'h13; write_strobe = 1'b1; reset_bar = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        reset_bar = 1'b1;
        check_en = 1;
        repeat (5) @(negedge clk);
        write_strobe = 1'b0;
        repeat (SYNC_STAGES + 4) @(negedge clk);
        checkOutput("no-commit single_mode", 64'(single_mode), 64'(0));

        // Single-mode init
        applyStimulus(1'b0, 8'h13, SYNC_STAGES + 2);
        applyStimulus(1'b1, 8'h48, SYNC_STAGES + 3);
        applyStimulus(1'b1, 8'h03, SYNC_STAGES + 2);
        checkOutput("single init_done", 64'(init_done), 64'(1));
        checkOutput("single vector_base", 64'(vector_base), 64'(5'h09));
        checkOutput("model vector_base", 64'(m_vb), 64'(5'h09));
        checkOutput("single upm/aeoi", 64'({upm, aeoi}), 64'(2'b11));
        checkOutput("single cascade_cfg", 64'(cascade_cfg), 64'(0));
        checkOutput("single imr", 64'(imr), 64'(IMR_INIT));

        // Cascade init then OCW1
        applyStimulus(1'b0, 8'h11, SYNC_STAGES + 2);
        applyStimulus(1'b1, 8'h20, SYNC_STAGES + 2);
        applyStimulus(1'b1, 8'h04, SYNC_STAGES + 2);
        applyStimulus(1'b1, 8'h01, SYNC_STAGES + 2);
        applyStimulus(1'b1, 8'hA5, SYNC_STAGES + 2);
        checkOutput("cascade cascade_cfg", 64'(cascade_cfg), 64'(8'h04));
        checkOutput("cascade init_done", 64'(init_done), 64'(1));
        checkOutput("cascade imr", 64'(imr), 64'(8'hA5));
        checkOutput("model imr", 64'(m_imr), 64'(8'hA5));

        // OCW2
        applyStimulus(1'b0, 8'h63, SYNC_STAGES + 2);
        checkOutput("ocw2 valid", 64'(snap_valid), 64'(1));
        checkOutput("ocw2 cmd", 64'(snap_cmd), 64'(3'b011));
        checkOutput("ocw2 level", 64'(snap_level), 64'(3));
        checkOutput("ocw2 valid drop", 64'(snap_valid_after), 64'(0));
        applyStimulus(1'b0, 8'h80, SYNC_STAGES + 2);
        checkOutput("rotate set", 64'(rotate_aeoi), 64'(1));
        applyStimulus(1'b0, 8'h00, SYNC_STAGES + 2);
        checkOutput("rotate clear", 64'(rotate_aeoi), 64'(0));

        // OCW3
        applyStimulus(1'b0, 8'h6B, SYNC_STAGES + 2);
        checkOutput("ocw3 smm/risr", 64'({special_mask, read_isr_sel}), 64'(2'b11));
        applyStimulus(1'b0, 8'h0C, SYNC_STAGES + 2);
        checkOutput("poll pulse", 64'(snap_poll), 64'(1));
        checkOutput("poll drop", 64'(snap_poll_after), 64'(0));
        checkOutput("ocw3 hold smm/risr", 64'({special_mask, read_isr_sel}), 64'(2'b11));

        // ICW1 from READY, then an ignored OCW2
        applyStimulus(1'b1, 8'hFF, SYNC_STAGES + 2);
        applyStimulus(1'b0, 8'h13, SYNC_STAGES + 2);
        checkOutput("re-icw1 init_done", 64'(init_done), 64'(0));
        checkOutput("re-icw1 imr", 64'(imr), 64'(IMR_INIT));
        applyStimulus(1'b0, 8'h20, SYNC_STAGES + 2);
        checkOutput("ignored ocw2 valid", 64'(snap_valid), 64'(0));
`ifdef PIC_SEQ_ERR_EN
        checkOutput("seq_err set", 64'(dut_err), 64'(1));
`endif

        // Random writes, biased so initialisation sequences complete regularly
        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(0, 99));
            dr = 8'($urandom);
            if (r < 20) begin
                a0r = 1'b0; dr[4] = 1'b1;
            end else if (r < 60) begin
                a0r = 1'b1;
            end else begin
                a0r = 1'b0; dr[4] = 1'b0;
            end
            applyStimulus(a0r, dr, int'($urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 5)));
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pic_init_sequencer.md
Name: pic_init_sequencer

Overview:
- Clocked command-word sequencer that sits directly downstream of the bus control/data-buffer stage.
- Synchronises the CPU write strobe and samples A0 and the internal data bus. Commits each completed write into the 8259A ICW1-ICW4 initialisation state machine or the OCW1-OCW3 operational registers.
- Outputs the decoded mode, vector, cascade and mask configuration, plus one-cycle command pulses, to the priority/interrupt-request logic.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on write_strobe. Legal range 1-3.
- IMR_INIT, 8'h00: IMR value loaded at reset and on every ICW1.

Ports:
- clk  input  1  system clock, rising edge
- reset_bar  input  1  asynchronous, active-low reset
- write_strobe  input  1  level, high while ~WR_bar & ~CS_bar; asynchronous to clk
- A0  input  1  address bit, stable while write_strobe is high
- data_in  input  8  internal data bus byte, stable while write_strobe is high
- init_done  output  1  high in READY state
- vector_base  output  5  ICW2 D[7:3] (T7-T3)
- single_mode  output  1  ICW1 SNGL
- ltim  output  1  ICW1 LTIM (1 = level-triggered)
- cascade_cfg  output  8  ICW3 byte
- upm, aeoi, master_slave, buf_mode, sfnm  output  1 each  ICW4 D0-D4
- imr  output  8  interrupt mask register (OCW1)
- ocw2_valid  output  1  one-cycle pulse per committed OCW2
- ocw2_cmd  output  3  R,SL,EOI; valid with ocw2_valid
- ocw2_level  output  3  L2-L0; valid with ocw2_valid
- rotate_aeoi  output  1  rotate-in-AEOI mode flag
- special_mask  output  1  special mask mode
- read_isr_sel  output  1  0 = IRR, 1 = ISR selected for reads
- poll_cmd  output  1  one-cycle pulse per OCW3 with P=1

Behaviour:
- Async reset:
  - state = WAIT_ICW1; sync chain cleared; armed = 0.
  - All outputs 0, except imr = IMR_INIT.
- Write capture:
  - s = last sync stage.
  - armed is set when s=0 is seen after reset.
  - While s=1, a holding register loads {A0, data_in} every cycle.
  - Commit happens on the cycle where s_prev=1, s=0 and armed=1.
  - Registered outputs update at that clock edge, i.e. SYNC_STAGES+1 cycles after write_strobe falls.
  - Minimum strobe width is SYNC_STAGES+2 clocks; shorter strobes may be lost.
  - A strobe that is high at reset release is never committed.
- Decode at commit. A0=0 and D4=1 is ICW1, accepted in any state, including mid-sequence:
  - single_mode=D1, ltim=D3.
  - Latch IC4=D0 internally.
  - Clear vector_base, cascade_cfg, all ICW4 fields, rotate_aeoi, special_mask and read_isr_sel.
  - imr = IMR_INIT; init_done = 0; state = WAIT_ICW2.
- State transitions on A0=1 commits:
  - WAIT_ICW1: write ignored.
  - WAIT_ICW2: vector_base = D[7:3]. Next state is WAIT_ICW3 if single_mode=0, else WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW3: cascade_cfg = D. Next state is WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW4: {sfnm, buf_mode, master_slave, aeoi, upm} = D[4:0]. Next state is READY.
  - READY: imr = D (OCW1).
- OCW2 (A0=0, D4=0, D3=0, READY only):
  - ocw2_valid = 1 for exactly one cycle, with ocw2_cmd = D[7:5] and ocw2_level = D[2:0].
  - cmd 100 sets rotate_aeoi; cmd 000 clears it.
- OCW3 (A0=0, D4=0, D3=1, READY only):
  - If D6=1: special_mask = D5.
  - If D1=1: read_isr_sel = D0.
  - If D2=1: poll_cmd pulses for one cycle.
  - Other fields are unchanged.
- OCW2/OCW3 writes in any state other than READY are ignored with no state change.
- At most one commit occurs per strobe. Both pulses are 0 on all non-commit cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: PIC_SEQ_ERR_EN.
- Defined:
  - Adds output seq_err (1 bit, reset 0), a sticky flag.
  - Set on any ignored commit: A0=1 in WAIT_ICW1, or OCW2/OCW3 outside READY.
  - Cleared only by ICW1 or reset.
- Undefined: port absent; ignored writes are silently dropped.

Test Plan:
- Single-mode init with ICW1=8'h13, ICW2=8'h48, ICW4=8'h03 -> init_done=1, vector_base=5'h09, upm=1, aeoi=1, cascade_cfg=8'h00, imr=IMR_INIT.
- Cascade init with ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01, then A0=1 write 8'hA5 -> cascade_cfg=8'h04, init_done=1, imr=8'hA5.
- OCW2 write 8'h63 in READY -> ocw2_valid high exactly one cycle, ocw2_cmd=3'b011, ocw2_level=3'd3. Then 8'h80 -> rotate_aeoi=1. Then 8'h00 -> rotate_aeoi=0.
- OCW3 write 8'h6B -> special_mask=1, read_isr_sel=1. Then 8'h0C -> poll_cmd pulses once, special_mask remains 1, read_isr_sel remains 1.
- ICW1=8'h13 issued in READY with imr=8'hFF -> state returns to WAIT_ICW2, init_done=0, imr=IMR_INIT. An OCW2 write 8'h20 issued next is ignored (no ocw2_valid; seq_err=1 when PIC_SEQ_ERR_EN is defined).
- reset_bar asserted while write_strobe is high, released while still high, strobe then falls -> no commit, state=WAIT_ICW1. The next full-width ICW1 strobe commits normally.
